// File: rtl/keycode_pkg.sv
// keycode_pkg
// Shared definitions for the keycode-to-action decoder: action indices,
// the HID usage code assigned to each action, special slot codes, the
// per-action auto-repeat state type and a slot extraction helper.
package keycode_pkg;

  localparam int N_ACTIONS = 8;
  localparam int MAX_SLOTS = 8;

  typedef enum logic [2:0] {
    ACT_LEFT      = 3'd0,
    ACT_RIGHT     = 3'd1,
    ACT_DOWN      = 3'd2,
    ACT_ROT_CW    = 3'd3,
    ACT_ROT_CCW   = 3'd4,
    ACT_HARD_DROP = 3'd5,
    ACT_START     = 3'd6,
    ACT_PAUSE     = 3'd7
  } action_t;

  // HID usage code per action; element [a] belongs to action index a.
  localparam logic [N_ACTIONS-1:0][7:0] ACT_CODE = {
    8'h29,  // PAUSE
    8'h28,  // START
    8'h2C,  // HARD_DROP
    8'h1D,  // ROT_CCW
    8'h52,  // ROT_CW
    8'h51,  // DOWN
    8'h4F,  // RIGHT
    8'h50   // LEFT
  };

  localparam logic [7:0] CODE_EMPTY    = 8'h00;
  localparam logic [7:0] CODE_ROLLOVER = 8'h01;

  // Actions whose simultaneous hold cancels auto-repeat (LEFT and RIGHT).
  localparam logic [N_ACTIONS-1:0] OPPOSED_PAIR = 8'b0000_0011;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } repeat_state_t;

  // Returns keycode byte idx of the concatenated 64-bit GPIO word.
  function automatic logic [7:0] slot_code(input logic [63:0] word, input int unsigned idx);
    return word[8*idx +: 8];
  endfunction

endpackage

// File: rtl/keycode_repeat_fsm.sv
// keycode_repeat_fsm
// Press / DAS / ARR auto-repeat sequencer for a single action.
// Ports:
//   clk        in  system clock
//   rst_n      in  asynchronous active-low reset
//   held       in  debounced held state of this action
//   tick       in  one-cycle frame tick
//   en_repeat  in  repeat counting allowed; when low the counter freezes
//                  and no repeat fires (press fires are unaffected)
//   fire       out registered one-cycle event (press or repeat)
module keycode_repeat_fsm
  import keycode_pkg::*;
#(
  parameter int DAS_TICKS = 10,
  parameter int ARR_TICKS = 2,
  parameter int CNT_W     = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic held,
  input  logic tick,
  input  logic en_repeat,
  output logic fire
);

  localparam logic [CNT_W-1:0] DAS_VAL  = CNT_W'(DAS_TICKS);
  localparam logic [CNT_W-1:0] ARR_VAL  = CNT_W'(ARR_TICKS);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  repeat_state_t    state_r;
  repeat_state_t    state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             fire_r;
  logic             fire_s;

  // Saturating increment: the counter must never wrap back to zero.
  assign cnt_inc_s = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);

  // Next-state, counter and fire decode.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    fire_s  = 1'b0;
    case (state_r)
      IDLE: begin
        // A tick arriving with the press is deliberately not counted.
        cnt_s = CNT_ZERO;
        if (held) begin
          state_s = DELAY;
          fire_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      DELAY: begin
        if (!held) begin
          state_s = IDLE;
          cnt_s   = CNT_ZERO;
        end else if (tick && en_repeat) begin
          if (cnt_inc_s == DAS_VAL) begin
            state_s = REPEAT;
            cnt_s   = CNT_ZERO;
            fire_s  = 1'b1;
          end else begin
            cnt_s = cnt_inc_s;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      REPEAT: begin
        if (!held) begin
          state_s = IDLE;
          cnt_s   = CNT_ZERO;
        end else if (tick && en_repeat) begin
          if (cnt_inc_s == ARR_VAL) begin
            cnt_s  = CNT_ZERO;
            fire_s = 1'b1;
          end else begin
            cnt_s = cnt_inc_s;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // State, counter and fire registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      fire_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      fire_r  <= fire_s;
    end
  end

  assign fire = fire_r;

endmodule

// File: rtl/keycode_action_decoder.sv
// keycode_action_decoder
// Turns raw HID keycode words from the GPIO into debounced held flags,
// press/auto-repeat events and a per-frame accumulated action vector.
// Ports:
//   clk            in  100 MHz system clock
//   reset_rtl_0    in  asynchronous active-low reset
//   keycode0       in  GPIO keycode word 0 (slots 0..3)
//   keycode1       in  GPIO keycode word 1 (slots 4..7)
//   vsync          in  raw vsync, asynchronous to clk
//   frame_tick     out one-cycle pulse per vsync rising edge
//   action_held    out debounced held state per action
//   action_event   out one-cycle pulse on press or auto-repeat
//   frame_actions  out events accumulated over the previous frame
module keycode_action_decoder
  import keycode_pkg::*;
#(
  parameter int                   N_SLOTS     = 6,
  parameter int                   DAS_TICKS   = 10,
  parameter int                   ARR_TICKS   = 2,
  parameter int                   CNT_W       = 5,
  parameter logic [N_ACTIONS-1:0] REPEAT_MASK = 8'b0000_0111
) (
  input  logic                 clk,
  input  logic                 reset_rtl_0,
  input  logic [31:0]          keycode0,
  input  logic [31:0]          keycode1,
  input  logic                 vsync,
  output logic                 frame_tick,
  output logic [N_ACTIONS-1:0] action_held,
  output logic [N_ACTIONS-1:0] action_event,
  output logic [N_ACTIONS-1:0] frame_actions
);

  localparam logic [N_ACTIONS-1:0] ACT_NONE = {N_ACTIONS{1'b0}};

  logic [63:0]          kc_word_s;
  logic [N_ACTIONS-1:0] match_s;
  logic                 rollover_s;
  logic [N_ACTIONS-1:0] raw_s;
  logic [N_ACTIONS-1:0] raw_r;
  logic [N_ACTIONS-1:0] held_r;
  logic                 sync1_r;
  logic                 sync2_r;
  logic                 edge_r;
  logic [1:0]           warm_r;
  logic                 tick_s;
  logic [N_ACTIONS-1:0] acc_r;
  logic [N_ACTIONS-1:0] frame_r;
  logic [N_ACTIONS-1:0] fire_s;
  logic                 opposed_s;
  logic [N_ACTIONS-1:0] en_repeat_s;

  assign kc_word_s = {keycode1, keycode0};

  // Slot scan: match every action code and detect a rollover report.
  // All eight slots are visited; slots at or beyond N_SLOTS are masked off.
  always_comb begin
    match_s    = ACT_NONE;
    rollover_s = 1'b0;
    for (int s = 0; s < MAX_SLOTS; s++) begin
      rollover_s = rollover_s
                 | ((s < N_SLOTS) && (slot_code(kc_word_s, s) == CODE_ROLLOVER));
      for (int act = 0; act < N_ACTIONS; act++) begin
        match_s[act] = match_s[act]
                     | ((s < N_SLOTS) && (slot_code(kc_word_s, s) == ACT_CODE[act]));
      end
    end
  end

  // A rollover report carries no key information, so keep the last raw value.
  assign raw_s = rollover_s ? raw_r : match_s;

  // Debounce: the GPIO words are not updated atomically, so a raw value is
  // accepted only after it has been seen on two consecutive edges.
  always_ff @(posedge clk or negedge reset_rtl_0) begin
    if (!reset_rtl_0) begin
      raw_r  <= ACT_NONE;
      held_r <= ACT_NONE;
    end else begin
      raw_r <= raw_s;
      if (raw_s == raw_r) begin
        held_r <= raw_s;
      end else begin
        held_r <= held_r;
      end
    end
  end

  // vsync synchroniser and rising-edge detector. The edge register is held
  // at 1 until the synchroniser has flushed its reset value, so a vsync that
  // is already high at reset release is not mistaken for a rising edge.
  always_ff @(posedge clk or negedge reset_rtl_0) begin
    if (!reset_rtl_0) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      warm_r  <= 2'b00;
      edge_r  <= 1'b1;
    end else begin
      sync1_r <= vsync;
      sync2_r <= sync1_r;
      warm_r  <= {warm_r[0], 1'b1};
      edge_r  <= warm_r[1] ? sync2_r : 1'b1;
    end
  end

  // Both operands are flops, so the pulse is clean for one cycle.
  assign tick_s = sync2_r & ~edge_r;

  // LEFT and RIGHT together cancel each other's repeat.
  assign opposed_s   = &(held_r | ~OPPOSED_PAIR);
  assign en_repeat_s = REPEAT_MASK & ~(opposed_s ? OPPOSED_PAIR : ACT_NONE);

  for (genvar a = 0; a < N_ACTIONS; a++) begin : g_act
    keycode_repeat_fsm #(
      .DAS_TICKS (DAS_TICKS),
      .ARR_TICKS (ARR_TICKS),
      .CNT_W     (CNT_W)
    ) u_fsm (
      .clk       (clk),
      .rst_n     (reset_rtl_0),
      .held      (held_r[a]),
      .tick      (tick_s),
      .en_repeat (en_repeat_s[a]),
      .fire      (fire_s[a])
    );
  end

  // Frame accumulator: an event on the tick cycle belongs to the frame
  // being closed, so it goes to frame_actions and not into the new acc.
  always_ff @(posedge clk or negedge reset_rtl_0) begin
    if (!reset_rtl_0) begin
      acc_r   <= ACT_NONE;
      frame_r <= ACT_NONE;
    end else if (tick_s) begin
      frame_r <= acc_r | fire_s;
      acc_r   <= ACT_NONE;
    end else begin
      acc_r   <= acc_r | fire_s;
      frame_r <= frame_r;
    end
  end

  assign frame_tick    = tick_s;
  assign action_held   = held_r;
  assign action_event  = fire_s;
  assign frame_actions = frame_r;

endmodule

// File: tb/tb_keycode_action_decoder.sv
// tb_keycode_action_decoder
// Self-checking bench: directed and randomized key holds; expected event
// counts and per-frame action vectors come from the press/DAS/ARR rules.
module tb_keycode_action_decoder;

  localparam int          DAS   = 10;
  localparam int          ARR   = 2;
  localparam logic [7:0]  RMASK = 8'b0000_0111;

  logic        clk = 1'b0;
  logic        reset_rtl_0;
  logic [31:0] keycode0;
  logic [31:0] keycode1;
  logic        vsync;
  logic        frame_tick;
  logic [7:0]  action_held;
  logic [7:0]  action_event;
  logic [7:0]  frame_actions;

  int total = 0;
  int bad   = 0;

  int         ev_cnt [8] = '{default: 0};
  int         base   [8] = '{default: 0};
  int         dbl        = 0;
  logic [7:0] prev_ev    = 8'h00;

  logic [7:0] code_tab [8] = '{8'h50, 8'h4F, 8'h51, 8'h52, 8'h1D, 8'h2C, 8'h28, 8'h29};

  always #5 clk = ~clk;

  keycode_action_decoder dut (
    .clk           (clk),
    .reset_rtl_0   (reset_rtl_0),
    .keycode0      (keycode0),
    .keycode1      (keycode1),
    .vsync         (vsync),
    .frame_tick    (frame_tick),
    .action_held   (action_held),
    .action_event  (action_event),
    .frame_actions (frame_actions)
  );

  // Event monitor: per-action pulse counts and multi-cycle pulse detection.
  always @(negedge clk) begin
    for (int a = 0; a < 8; a++) begin
      if (action_event[a] === 1'b1) ev_cnt[a] <= ev_cnt[a] + 1;
    end
    if ((action_event & prev_ev) != 8'h00) dbl <= dbl + 1;
    prev_ev <= action_event;
  end

  // Events expected for one action held for t counted ticks.
  function automatic int exp_events(int a, int t);
    if (RMASK[a] == 1'b0 || t < DAS) return 1;
    return 2 + (t - DAS) / ARR;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    for (int a = 0; a < 8; a++) base[a] = ev_cnt[a];
  endtask

  task automatic chk_ev(input string tag, input int a, input int exp);
    chk($sformatf("%s_ev%0d", tag, a), 64'(ev_cnt[a] - base[a]), 64'(exp));
  endtask

  // One video frame: vsync high 4 cycles, low 8. Exactly one tick must be
  // seen; fa returns frame_actions as loaded by that tick.
  task automatic frame(output logic [7:0] fa);
    int   nt;
    logic prev;
    vsync = 1'b1;
    nt    = 0;
    prev  = 1'b0;
    fa    = 8'h00;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (prev) fa = frame_actions;
      prev = frame_tick;
      if (frame_tick === 1'b1) nt++;
      if (i == 3) vsync = 1'b0;
    end
    chk("tick_count", 64'(nt), 64'd1);
  endtask

  task automatic frames(input int n);
    logic [7:0] fa;
    for (int i = 0; i < n; i++) frame(fa);
  endtask

  initial begin
    logic [7:0]  fa;
    logic [63:0] kw;
    logic [7:0]  onehot;
    logic        expb;
    int          nt;
    int          a;
    int          slot;
    int          t;

    // Reset with vsync high across release.
    reset_rtl_0 = 1'b0;
    vsync       = 1'b1;
    keycode0    = 32'h0;
    keycode1    = 32'h0;
    idle(3);
    chk("reset_outputs", {frame_tick, action_held, action_event, frame_actions}, 64'd0);
    reset_rtl_0 = 1'b1;
    nt = 0;
    repeat (10) begin
      @(negedge clk);
      if (frame_tick !== 1'b0) nt++;
    end
    chk("no_tick_at_release", 64'(nt), 64'd0);
    chk("idle_outputs", {action_held, action_event, frame_actions}, 64'd0);
    vsync = 1'b0;
    idle(8);

    // LEFT held for 40 ticks: press, then repeats at ticks 10, 12, ... 40.
    snap();
    keycode0 = 32'h0000_0050;
    idle(4);
    chk("left_held", action_held, 8'h01);
    chk_ev("left_press", 0, 1);
    for (int j = 1; j <= 41; j++) begin
      if (j == 41) begin
        keycode0 = 32'h0;
        idle(4);
      end
      frame(fa);
      expb = (j == 1) || ((j - 1) >= DAS && ((j - 1 - DAS) % ARR) == 0);
      chk($sformatf("left_frame%0d", j), fa, {7'b0, expb});
    end
    frame(fa);
    chk("left_frame_quiet", fa, 8'h00);
    for (int b = 0; b < 8; b++) chk_ev("left40", b, (b == 0) ? exp_events(0, 40) : 0);

    // Randomized holds: random action, slot, filler codes and hold length.
    // Slots 6 and 7 carry action codes that must be ignored.
    for (int it = 0; it < 6; it++) begin
      a    = $urandom_range(0, 7);
      slot = $urandom_range(0, 5);
      t    = $urandom_range(1, 22);
      for (int s = 0; s < 8; s++) begin
        if (s >= 6)                      kw[8*s +: 8] = code_tab[$urandom_range(0, 7)];
        else if ($urandom_range(0, 1) == 1) kw[8*s +: 8] = 8'($urandom_range(4, 28));
        else                             kw[8*s +: 8] = 8'h00;
      end
      kw[8*slot +: 8] = code_tab[a];
      onehot = 8'h01 << a;
      snap();
      {keycode1, keycode0} = kw;
      idle(4);
      chk($sformatf("rand%0d_held", it), action_held, onehot);
      frames(t);
      keycode0 = 32'h0;
      keycode1 = 32'h0;
      idle(4);
      chk($sformatf("rand%0d_release", it), action_held, 8'h00);
      for (int b = 0; b < 8; b++)
        chk_ev($sformatf("rand%0d", it), b, (b == a) ? exp_events(a, t) : 0);
    end

    // HARD_DROP is not repeatable: one event over 40 ticks.
    snap();
    keycode0 = 32'h0000_002C;
    idle(4);
    chk("drop_held", action_held, 8'h20);
    frames(40);
    keycode0 = 32'h0;
    idle(4);
    for (int b = 0; b < 8; b++) chk_ev("drop40", b, (b == 5) ? 1 : 0);

    // Opposition: LEFT counts 6, frozen while RIGHT is also held, then resumes.
    snap();
    keycode0 = 32'h0000_0050;
    idle(4);
    frames(6);
    keycode0 = 32'h0000_504F;
    idle(4);
    chk("opp_held", action_held, 8'h03);
    frames(30);
    chk_ev("opp30", 0, 1);
    chk_ev("opp30", 1, 1);
    keycode0 = 32'h0000_0050;
    idle(4);
    chk("opp_right_off", action_held, 8'h01);
    frames(3);
    chk_ev("opp_resume3", 0, 1);
    frames(1);
    chk_ev("opp_resume4", 0, 2);
    keycode0 = 32'h0;
    idle(4);
    chk_ev("opp_end", 1, 1);

    // Rollover keeps the held vector and fires nothing.
    snap();
    keycode0 = 32'h0000_0050;
    idle(4);
    frames(2);
    keycode0 = 32'h0000_5001;
    idle(4);
    chk("rollover_held", action_held, 8'h01);
    frames(2);
    keycode0 = 32'h0000_2C01;
    idle(4);
    chk("rollover_drop_held", action_held, 8'h01);
    frames(1);
    chk_ev("rollover", 0, 1);
    chk_ev("rollover", 5, 0);
    keycode0 = 32'h0;
    idle(4);
    chk("rollover_release", action_held, 8'h00);

    // Slot range: slot 6 is outside N_SLOTS, slot 5 is inside.
    snap();
    keycode1 = 32'h0050_0000;
    idle(4);
    chk("slot6_ignored", action_held, 8'h00);
    keycode1 = 32'h0000_5000;
    idle(4);
    chk("slot5_used", action_held, 8'h01);
    keycode1 = 32'h0;
    idle(4);
    chk_ev("slots", 0, 1);

    // One-cycle glitches are filtered by the debounce.
    snap();
    keycode0 = 32'h0000_0050;
    idle(4);
    keycode0 = 32'h0;
    @(negedge clk);
    keycode0 = 32'h0000_0050;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("glitch_off%0d", i), action_held, 8'h01);
    end
    keycode0 = 32'h0;
    idle(4);
    chk_ev("glitch_off", 0, 1);
    snap();
    keycode0 = 32'h0000_0050;
    @(negedge clk);
    keycode0 = 32'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("glitch_on%0d", i), action_held, 8'h00);
    end
    chk_ev("glitch_on", 0, 0);

    // Press event on the tick cycle lands in that tick's frame_actions.
    snap();
    keycode0 = 32'h0000_0050;
    @(negedge clk);
    frame(fa);
    chk("press_on_tick", fa, 8'h01);
    frame(fa);
    chk("after_press_tick", fa, 8'h00);
    keycode0 = 32'h0;
    idle(4);
    chk_ev("press_on_tick", 0, 1);

    // Held rise on the tick cycle: that tick is not counted.
    snap();
    keycode0 = 32'h0000_0050;
    frame(fa);
    frames(DAS - 1);
    chk_ev("rise_on_tick_9", 0, 1);
    frames(1);
    chk_ev("rise_on_tick_10", 0, 2);
    keycode0 = 32'h0;
    idle(4);

    // Reset during REPEAT clears at once; a key still held re-presses.
    snap();
    keycode0 = 32'h0000_0050;
    idle(4);
    frames(13);
    reset_rtl_0 = 1'b0;
    #1;
    chk("reset_clear", {frame_tick, action_held, action_event, frame_actions}, 64'd0);
    idle(2);
    reset_rtl_0 = 1'b1;
    idle(6);
    chk("reset_reheld", action_held, 8'h01);
    chk_ev("reset_repress", 0, exp_events(0, 12) + 1);
    keycode0 = 32'h0;
    idle(4);

    chk("event_width", 64'(dbl), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keycode_action_decoder.md
# keycode_action_decoder

Converts raw USB HID keycode words from the MicroBlaze GPIO into debounced, per-frame Tetris action events with DAS/ARR auto-repeat, generalising the single-byte `keycode0_gpio[7:0]` path to up to eight simultaneous key slots. It sits between `mb_block` and `tetris_game_controller`, all on the 100 MHz domain. It delivers a frame-aligned action vector that the vsync-clocked game logic samples once per frame.

## Interface
- `N_SLOTS`, 6: keycode bytes scanned, 1..8; slot i = `{keycode1,keycode0}[8i+7:8i]`.
- `DAS_TICKS`, 10: frame ticks of hold before the first auto-repeat, 1..2^CNT_W-1.
- `ARR_TICKS`, 2: frame ticks between auto-repeats, 1..2^CNT_W-1.
- `CNT_W`, 5: per-action tick counter width.
- `REPEAT_MASK`, 8'b0000_0111: actions eligible for auto-repeat (bit = action index).
- `clk`  in  1  system clock, 100 MHz.
- `reset_rtl_0`  in  1  asynchronous active-low reset.
- `keycode0`  in  32  GPIO keycode word 0, slots 0..3.
- `keycode1`  in  32  GPIO keycode word 1, slots 4..7.
- `vsync`  in  1  raw vsync from the 25 MHz pixel domain; asynchronous to `clk`.
- `frame_tick`  out  1  one-cycle pulse per vsync rising edge.
- `action_held`  out  8  debounced held state per action.
- `action_event`  out  8  one-cycle pulse on a press or an auto-repeat fire.
- `frame_actions`  out  8  events accumulated over the previous frame; stable between ticks.

## Operation
- Action indices, fixed at 8:
  - 0 LEFT 0x50, 1 RIGHT 0x4F, 2 DOWN 0x51, 3 ROT_CW 0x52, 4 ROT_CCW 0x1D.
  - 5 HARD_DROP 0x2C, 6 START 0x28, 7 PAUSE 0x29.
- Raw held vector: bit a = OR over slots of (slot == code[a]).
  - 0x00 means an empty slot.
  - If any slot == 0x01 (rollover), the raw vector holds its previous value.
- Debounce for non-atomic GPIO updates:
  - The raw vector is registered as `raw_q`.
  - `action_held` loads raw only when raw == `raw_q`, i.e. the same value on two consecutive edges.
- Frame tick:
  - `vsync` passes through a 2-flop synchroniser, then an edge register.
  - Tick = sync & ~edge.
- Per-action FSM with states IDLE, DELAY, REPEAT:
  - IDLE -> DELAY on held rise: fire, cnt=0.
  - DELAY: on each tick cnt++; when cnt reaches DAS_TICKS, fire, cnt=0, go to REPEAT.
  - REPEAT: on each tick cnt++; when cnt reaches ARR_TICKS, fire, cnt=0.
  - Any state -> IDLE on held fall, cnt=0, no fire.
  - Actions not in REPEAT_MASK stay in DELAY with cnt frozen; press fire only.
- Opposition rule: while LEFT and RIGHT are both held, repeat fires for both are suppressed and counters freeze. Press fires are unaffected.
- Accumulator:
  - `acc |= action_event` each cycle.
  - On a tick: `frame_actions <= acc | action_event`, and `acc <= 0`.
  - An event on the tick cycle lands in `frame_actions`, not the new `acc`.
- Counter arithmetic is unsigned CNT_W and never wraps; the compare is equality against the parameter.

## Timing
- All outputs reset to 0, as do `raw_q`, `acc`, counters and the synchroniser.
- The FSMs reset to IDLE.
- The edge register resets to 1, so vsync being high at reset release gives no spurious tick.
- Keycode stable before edge k:
  - `raw_q` updates at edge k.
  - `action_held` updates at edge k+1.
  - `action_event` is high for exactly one cycle after edge k+2.
- vsync rise to `frame_tick`: 2-3 clk edges (synchroniser uncertainty). The pulse width is exactly 1 cycle.
- The tick and a held rise on the same cycle: the press fires and cnt stays 0; that tick is not counted.
- Release and press inside one debounce window are filtered; no event.
- Reset mid-repeat:
  - Immediate clear.
  - After release, keys still held re-fire as fresh presses.

## Structure
- `keycode_pkg` holds:
  - The action index enum.
  - The `ACT_CODE[8]` HID code constant array.
  - The `N_ACTIONS=8` constant.
  - The `repeat_state_t` typedef (IDLE, DELAY, REPEAT).
- Sub-module `keycode_repeat_fsm`: one action's FSM and counter. It is instantiated 8x via generate, with an `en_repeat` input driven from REPEAT_MASK and the opposition rule.
- Synchroniser, debounce and accumulator live in the top.

## Test plan
- Keycode0 = 0x00000050 held 40 ticks, defaults:
  - One event at press.
  - Repeats at ticks 10, 12, 14, … (16 repeats total).
  - `frame_actions[0]` is set in each corresponding frame.
- Keycode0 = 0x0000002C held 40 ticks: exactly one HARD_DROP event; no repeats.
- Keycode0 = 0x0000504F (LEFT+RIGHT) held 30 ticks: one press event each; no repeats. Releasing RIGHT resumes LEFT counting from its frozen cnt.
- Keycode0 = 0x00005001 (rollover in slot 0) after LEFT is held: `action_held` is unchanged and no events fire.
- Keycode0 goes 0x50 -> 0x00 -> 0x50 on consecutive cycles: no release and no re-press event.
- vsync high across reset release:
  - No tick.
  - LEFT press coinciding with a tick appears in that tick's `frame_actions[0]`.
  - Assert reset_rtl_0=0 during REPEAT: all outputs 0 within the same cycle.
